// File: rtl/ula_multiciclo.sv
// ula_multiciclo -- multi-cycle ALU for the multicycle MIPS datapath.
//
// Single-cycle ops (AND, OR, ADD, SUB, SLT, NOR, unknown) finish one cycle
// after start. MULTU (shift-add) and DIVU (restoring shift-subtract) run one
// step per cycle for WIDTH cycles. Results are registered and only updated
// when an operation completes.
//
// Optional feature: define ULA_DIV_EN to build the DIVU (1001) datapath.
// Without it, 1001 is treated as an unknown opcode.
//
// Handshake: start is sampled on a rising edge whenever busy=0 (IDLE or DONE
// state); ULAopcode/A/B are captured on that same edge. busy=1 while an
// iterative op runs and start is ignored then. done pulses for exactly one
// cycle per accepted start; R/HI/Z/O are valid from that cycle and hold until
// the next done.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          launch request
//   ULAopcode      4-bit operation select
//   A, B           WIDTH-bit operands
//   R, HI          result low word / high word (product hi or remainder)
//   Z, O           zero flag (R==0), overflow/exception flag
//   busy, done     iterative op in progress / completion pulse
//   state_dbg      current FSM state (0 IDLE, 1 CALC, 2 DONE)
module ula_multiciclo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       ULAopcode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] HI,
    output logic             Z,
    output logic             O,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_INIT = WIDTH'(WIDTH);

    state_t state, state_nx;

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] work_hi;   // partial product high / partial remainder
    logic [WIDTH-1:0] work_lo;   // multiplier bits / dividend-quotient bits
    logic [WIDTH-1:0] opnd;      // multiplicand or divisor

    logic accept;
    logic is_mult;
    logic is_div;
    logic is_iter;
    logic last_step;

    assign accept    = start && (state != S_CALC);
    assign is_mult   = (ULAopcode == 4'b1000);
`ifdef ULA_DIV_EN
    assign is_div    = (ULAopcode == 4'b1001);
`else
    assign is_div    = 1'b0;
`endif
    assign is_iter   = is_mult || is_div;
    assign last_step = (cnt == {{(WIDTH-1){1'b0}}, 1'b1});

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start)      state_nx = is_iter ? S_CALC : S_DONE;
                else            state_nx = S_IDLE;
            end
            S_CALC: begin
                if (last_step)  state_nx = S_DONE;
            end
            default:            state_nx = S_IDLE;
        endcase
    end

    assign busy      = (state == S_CALC);
    assign done      = (state == S_DONE);
    assign state_dbg = state;

    // ---------------- single-cycle ops ----------------
    logic [WIDTH-1:0] sum, diff, sc_r;
    logic             sc_o;

    assign sum  = A + B;
    assign diff = A - B;

    always_comb begin
        sc_r = '0;
        sc_o = 1'b0;
        case (ULAopcode)
            4'b0000: sc_r = A & B;
            4'b0001: sc_r = A | B;
            4'b0010: begin
                sc_r = sum;
                sc_o = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            4'b0110: begin
                sc_r = diff;
                sc_o = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            // Signed compare is immune to the wrap of A-B.
            4'b0111: sc_r = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            4'b1100: sc_r = ~(A | B);
            default: sc_r = '0;
        endcase
    end

    // ---------------- iterative step logic ----------------
    // Multiply: add multiplicand when the multiplier LSB is set, then shift
    // the {hi,lo} pair right by one, carry included.
    logic [WIDTH:0]   mul_add;
    logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx;

    assign mul_add   = {1'b0, work_hi} + {1'b0, (work_lo[0] ? opnd : {WIDTH{1'b0}})};
    assign mul_hi_nx = mul_add[WIDTH:1];
    assign mul_lo_nx = {mul_add[0], work_lo[WIDTH-1:1]};

    logic [WIDTH-1:0] fin_r, fin_hi, step_hi, step_lo;
    logic             fin_o;

`ifdef ULA_DIV_EN
    // Restoring divide: shift next dividend bit into the remainder, subtract
    // the divisor when it fits, and shift the quotient bit into work_lo.
    // With a zero divisor every step "fits", giving an all-ones quotient and
    // the dividend as remainder without any special-casing.
    logic             op_div;
    logic [WIDTH:0]   div_shift, div_sub;
    logic             div_ge;
    logic [WIDTH-1:0] div_hi_nx, div_lo_nx;

    assign div_shift = {work_hi, work_lo[WIDTH-1]};
    assign div_sub   = div_shift - {1'b0, opnd};
    assign div_ge    = (div_shift >= {1'b0, opnd});
    assign div_hi_nx = div_ge ? div_sub[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_lo_nx = {work_lo[WIDTH-2:0], div_ge};

    assign step_hi = op_div ? div_hi_nx : mul_hi_nx;
    assign step_lo = op_div ? div_lo_nx : mul_lo_nx;
    assign fin_r   = step_lo;
    assign fin_hi  = step_hi;
    assign fin_o   = op_div ? (opnd == '0) : (mul_hi_nx != '0);
`else
    assign step_hi = mul_hi_nx;
    assign step_lo = mul_lo_nx;
    assign fin_r   = mul_lo_nx;
    assign fin_hi  = mul_hi_nx;
    assign fin_o   = (mul_hi_nx != '0);
`endif

    // ---------------- datapath / result registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            work_hi <= '0;
            work_lo <= '0;
            opnd    <= '0;
            R       <= '0;
            HI      <= '0;
            Z       <= 1'b0;
            O       <= 1'b0;
`ifdef ULA_DIV_EN
            op_div  <= 1'b0;
`endif
        end else if (accept) begin
            if (is_iter) begin
                cnt     <= CNT_INIT;
                work_hi <= '0;
                work_lo <= is_div ? A : B;
                opnd    <= is_div ? B : A;
`ifdef ULA_DIV_EN
                op_div  <= is_div;
`endif
            end else begin
                R  <= sc_r;
                HI <= '0;
                Z  <= (sc_r == '0);
                O  <= sc_o;
            end
        end else if (state == S_CALC) begin
            cnt     <= cnt - 1'b1;
            work_hi <= step_hi;
            work_lo <= step_lo;
            if (last_step) begin
                R  <= fin_r;
                HI <= fin_hi;
                Z  <= (fin_r == '0);
                O  <= fin_o;
            end
        end
    end

endmodule

// File: tb/tb_ula_multiciclo.sv
// Testbench for ula_multiciclo (WIDTH=32). Expected results are pushed to a
// scoreboard queue when an op is launched and popped when done is seen.
module tb_ula_multiciclo;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   opcode;
  logic [W-1:0] a, b;
  logic [W-1:0] r, hi;
  logic         z, o, busy, done;
  logic [1:0]   state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2*W+1:0] exp_q[$];
  string          tag_q[$];

  ula_multiciclo #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .ULAopcode(opcode),
    .A(a), .B(b), .R(r), .HI(hi), .Z(z), .O(o),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- check ----------------
  task automatic check(input string tag, input logic [2*W+1:0] obs, input logic [2*W+1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [2*W+1:0] model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] p;
    logic [W-1:0]   rr, hh;
    logic           oo;
    rr = '0; hh = '0; oo = 1'b0;
    case (op)
      4'h0: rr = x & y;
      4'h1: rr = x | y;
      4'h2: begin rr = x + y; oo = (x[W-1] == y[W-1]) && (rr[W-1] != x[W-1]); end
      4'h6: begin rr = x - y; oo = (x[W-1] != y[W-1]) && (rr[W-1] != x[W-1]); end
      4'h7: rr = ($signed(x) < $signed(y)) ? 1 : 0;
      4'hC: rr = ~(x | y);
      4'h8: begin
        p  = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        rr = p[W-1:0]; hh = p[2*W-1:W]; oo = (hh != 0);
      end
`ifdef ULA_DIV_EN
      4'h9: begin
        if (y == 0) begin rr = '1; hh = x; oo = 1'b1; end
        else        begin rr = x / y; hh = x % y; end
      end
`endif
      default: ;
    endcase
    return {rr, hh, (rr == 0), oo};
  endfunction

  function automatic int latency(input logic [3:0] op);
`ifdef ULA_DIV_EN
    if (op == 4'h9) return W + 1;
`endif
    return (op == 4'h8) ? W + 1 : 1;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", {{(2*W+1){1'b0}}, done}, '0);
      end else begin
        logic [2*W+1:0] e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, {r, hi, z, o}, e);
      end
    end
  end

  // ---------------- driver ----------------
  // Launch one op, then scramble inputs to prove they were captured. With
  // poke set, a start with ADD is raised mid-busy and must be ignored.
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input string tag, input bit poke);
    int lat, n, nbusy;
    lat = latency(op);
    exp_q.push_back(model(op, av, bv));
    tag_q.push_back(tag);
    @(negedge clk);
    start = 1'b1; opcode = op; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; opcode = 4'($urandom_range(0, 15));
    n = 1; nbusy = 0;
    while (!done && n < lat + 4) begin
      if (busy) nbusy++;
      if (poke && n == 5) begin start = 1'b1; opcode = 4'h2; end
      else start = 1'b0;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 66'(n), 66'(lat));
    check({tag, "_busy_cycles"}, 66'(nbusy), 66'(lat - 1));
    check({tag, "_busy_at_done"}, {65'b0, busy}, 66'd0);
    if (!done) begin
      void'(exp_q.pop_back());
      void'(tag_q.pop_back());
    end
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] ops[8];
    rst = 1'b1; start = 1'b0; opcode = '0; a = '0; b = '0;
    ops = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC, 4'h8, 4'h9};
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_outputs", {r, hi, z, o}, '0);
    check("rst_busy", {65'b0, busy}, '0);
    check("rst_done", {65'b0, done}, '0);
    check("rst_state", {64'b0, state_dbg}, '0);
    rst = 1'b0;

    do_op(4'h2, 32'd5, 32'd7, "add_5_7", 1'b0);
    do_op(4'h2, 32'h7FFFFFFF, 32'd1, "add_ovf", 1'b0);
    do_op(4'h6, 32'h80000000, 32'd1, "sub_ovf", 1'b0);
    do_op(4'h7, 32'hFFFFFFFF, 32'd1, "slt_neg", 1'b0);
    do_op(4'h6, 32'd9, 32'd9, "sub_zero", 1'b0);
    do_op(4'h8, 32'hFFFFFFFF, 32'd2, "multu_poke", 1'b1);
    do_op(4'h9, 32'd100, 32'd7, "divu_100_7", 1'b0);
    do_op(4'h9, 32'd5, 32'd0, "divu_by_zero", 1'b0);
    do_op(4'hF, 32'h1234, 32'h5678, "unknown_op", 1'b0);

    // Reset during CALC: no done, outputs cleared
    @(negedge clk);
    start = 1'b1; opcode = 4'h8; a = 32'hDEAD; b = 32'hBEEF;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("calc_busy_before_rst", {65'b0, busy}, 66'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_calc_state", {64'b0, state_dbg}, '0);
    check("rst_calc_busy", {65'b0, busy}, '0);
    check("rst_calc_done", {65'b0, done}, '0);
    check("rst_calc_outputs", {r, hi, z, o}, '0);
    repeat (40) @(negedge clk);

    // rst and start together: start dropped
    rst = 1'b1; start = 1'b1; opcode = 4'h2; a = 32'd1; b = 32'd1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_start_done", {65'b0, done}, '0);
    check("rst_start_state", {64'b0, state_dbg}, '0);
    @(negedge clk);

    // Back-to-back AND then OR with start held
    exp_q.push_back(model(4'h0, 32'hF0F0F0F0, 32'hFF00FF00)); tag_q.push_back("b2b_and");
    exp_q.push_back(model(4'h1, 32'h0000000F, 32'h000000F0)); tag_q.push_back("b2b_or");
    start = 1'b1; opcode = 4'h0; a = 32'hF0F0F0F0; b = 32'hFF00FF00;
    @(negedge clk);
    check("b2b_done1", {65'b0, done}, 66'd1);
    opcode = 4'h1; a = 32'h0000000F; b = 32'h000000F0;
    @(negedge clk);
    check("b2b_done2", {65'b0, done}, 66'd1);
    start = 1'b0;
    @(negedge clk);
    check("b2b_done_end", {65'b0, done}, '0);

    // Random mix
    for (int i = 0; i < 10; i++) begin
      logic [3:0] op;
      logic [W-1:0] av, bv;
      op = ops[$urandom_range(0, 7)];
      av = $urandom;
      bv = (op == 4'h9) ? W'($urandom_range(0, 1000)) : W'($urandom);
      do_op(op, av, bv, $sformatf("rand%0d_op%h", i, op), 1'b0);
    end

    repeat (3) @(negedge clk);
    check("queue_drain", 66'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ula_multiciclo.md
# ula_multiciclo

Parametrised multi-cycle ALU for the multicycle MIPS datapath. It replaces the single-cycle combinational ALU. It keeps the same 4-bit opcode map and Z/O flags and adds unsigned iterative multiply and divide with a HI output word. A start/busy/done handshake lets the control FSM launch an operation and wait for the registered result.

## Interface
- `WIDTH`, 32: operand and result width; must be ≥ 4.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: launch request; sampled only when `busy`=0.
- `ULAopcode` in 4: operation select, captured with `start`.
- `A`, `B` in WIDTH: operands, captured with `start`.
- `R` out WIDTH: result (low word of product, quotient).
- `HI` out WIDTH: high word of product or remainder; 0 for single-cycle ops.
- `Z` out 1: `R` == 0.
- `O` out 1: overflow / exception flag, per opcode.
- `busy` out 1: iterative operation in progress.
- `done` out 1: one-cycle pulse; `R`/`HI`/`Z`/`O` valid from this cycle.

## Operation
- FSM states:
  - IDLE → (start, single-cycle op) → DONE.
  - IDLE → (start, MULTU/DIVU) → CALC.
  - CALC → (counter reaches 0) → DONE.
  - DONE → IDLE, or → DONE/CALC if `start` is asserted in DONE (back-to-back start allowed).
- `busy`=1 only in CALC. `start` while busy is ignored, with no effect on state or operands.
- Opcodes:
  - 0000 AND.
  - 0001 OR.
  - 0010 ADD.
  - 0110 SUB.
  - 0111 SLT: signed; R=1 if A<B, overflow-corrected.
  - 1100 NOR: ~(A|B).
  - 1000 MULTU: {HI,R} = A×B unsigned, 2·WIDTH-bit.
  - 1001 DIVU: R = A/B, HI = A%B, unsigned restoring.
  - All other opcodes: R=0, HI=0, O=0, completing in 1 cycle.
- Flag O per opcode:
  - ADD: O = (A[msb]==B[msb]) & (R[msb]!=A[msb]).
  - SUB: O = (A[msb]!=B[msb]) & (R[msb]!=A[msb]).
  - MULTU: O = (HI != 0).
  - DIVU: O = (B == 0).
  - All other opcodes: O=0.
- Z is computed from the final R for every opcode (not A−B).
- Arithmetic wraps modulo 2^WIDTH. The carry out of ADD/SUB is discarded.
- MULTU datapath: one shift-add step per cycle over a WIDTH-bit counter.
- DIVU datapath: one shift-subtract step per cycle over a WIDTH-bit counter.
- Divide by zero: runs full latency, then yields R = all ones, HI = A, O=1.
- Outputs hold their last values until the next `done`. Intermediate iteration values never appear on `R`/`HI`.

## Timing
- Reset values: state IDLE, `R`=0, `HI`=0, `Z`=0, `O`=0, `busy`=0, `done`=0, counter=0.
- Single-cycle ops: `start` sampled at edge n → `done`=1 and outputs valid during cycle n+1.
- MULTU/DIVU: `start` at edge n → `busy`=1 for cycles n+1 … n+WIDTH → `done`=1 in cycle n+WIDTH+1, with `busy`=0.
- `done` is high exactly one cycle per accepted `start`.
- `start` held high in DONE launches a new operation, so throughput is 1 op/cycle for single-cycle ops.
- `rst` mid-CALC: next cycle is IDLE. The partial result is discarded, outputs return to reset values, and no `done` is issued.
- `rst` and `start` in the same cycle: `rst` wins and the start is dropped.
- A/B/opcode changes after capture do not affect an operation in flight.

## Configuration
- `ULA_DIV_EN` defined:
  - DIVU (1001) is built as specified above.
- `ULA_DIV_EN` undefined:
  - The divider datapath is removed.
  - 1001 behaves as an unknown opcode: 1-cycle, R=0, HI=0, O=0, Z=1.
  - MULTU and all other behaviour are unchanged.

## Test plan
All scenarios use WIDTH=32.
- Reset and launch: after reset, all outputs are 0. Then ADD A=5, B=7 → next cycle `done`=1, R=12, Z=0, O=0, HI=0.
- Overflow and SLT:
  - ADD 0x7FFFFFFF+1 → R=0x80000000, O=1.
  - SUB 0x80000000−1 → R=0x7FFFFFFF, O=1.
  - SLT A=0xFFFFFFFF (−1), B=1 → R=1.
  - SUB 9−9 → R=0, Z=1.
- MULTU 0xFFFFFFFF×2 → `busy` for 32 cycles, `done` on cycle 33, R=0xFFFFFFFE, HI=1, O=1. A `start` with ADD asserted mid-busy is ignored.
- DIVU 100/7 → `done` on cycle 33, R=14, HI=2, O=0. DIVU 5/0 → R=0xFFFFFFFF, HI=5, O=1. Without `ULA_DIV_EN`: DIVU 100/7 → 1-cycle `done`, R=0, Z=1.
- Reset in CALC at cycle 10 of MULTU → IDLE next cycle, `busy`=0, no `done`, outputs 0.
- Back-to-back: AND then OR with `start` held → `done` on two consecutive cycles, each with its correct result. Unknown opcode 1111 → R=0, Z=1, O=0.
